jtag_tap_dtm: RTL and testbench
===============================

// Module: jtag_tap_dtm
// PURPOSE
//  JTAG responder: TAP controller plus RISC-V debug transport module (DTM), sampling the host pins in the clk domain.
//  Decodes TCK/TMS/TDI from an external probe or bench, drives TDO, and issues DMI requests to the debug module.
//  Sits between the SoC jtag_TCK/TMS/TDI/TDO pins and the DM request/response interface.
// PARAMETERS
//  SYNC_STAGES   2             synchroniser depth for TCK/TMS/TDI (min 2)
//  IR_BITS       5             instruction register width
//  DMI_ABITS     6             DMI address width; DMI DR = DMI_ABITS+34 = 40 bits
//  IDCODE_VAL    32'h1E200A6F  IDCODE DR value, bit0 must be 1
// PORTS
//  clk            in   1   system clock; TCK must be slower than clk/8
//  rst            in   1   asynchronous, active-high reset
//  jtag_TCK       in   1   JTAG clock (sampled, not used as a clock)
//  jtag_TMS       in   1   JTAG mode select
//  jtag_TDI       in   1   JTAG data in, LSB first
//  jtag_TDO       out  1   JTAG data out, LSB first
//  dmi_req_valid  out  1   DMI request valid
//  dmi_req_ready  in   1   DM accepts request
//  dmi_req_addr   out  6   DMI address
//  dmi_req_data   out  32  DMI write data
//  dmi_req_op     out  2   1=read, 2=write
//  dmi_resp_valid in   1   one-cycle response pulse
//  dmi_resp_data  in   32  response data
//  tap_state      out  4   current TAP state (debug/observability)
// BEHAVIOUR
//  - Reset (async): jtag_TDO=0, dmi_req_*=0, tap_state=TEST_LOGIC_RESET(4'h0), IR=IDCODE (or BYPASS, see CONFIGURATION), busy/sticky=0.
//  - Pins pass SYNC_STAGES flops, then an edge-detect flop. Rise/fall of TCK is seen SYNC_STAGES+1 clk after the pin edge.
//  - On TCK rise: sample TMS/TDI and advance the 16-state IEEE 1149.1 FSM.
//  - FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the matching IR states.
//  - 5 consecutive TMS=1 rises reach TLR from any state. TLR forces IR to its reset value.
//  - CAP_IR loads IR shift reg with 5'b00001. In SH_IR, shift right with TDI into MSB. UPD_IR copies to IR.
//  - DRs selected by IR:
//      0x01 IDCODE 32b
//      0x10 DTMCS 32b
//      0x11 DMI 40b {addr[39:34], data[33:2], op[1:0]}
//      others BYPASS 1b (capture 0)
//  - CAP_DR loads:
//      DTMCS = {14'b0, 2'b0, 1'b0, idle=3'd5, dmistat[1:0], abits=6'd6, version=4'd1}
//      DMI   = {last_addr, last_resp_data, status}; status=2'b11 while a request is outstanding or sticky busy is set, else 2'b00
//  - On TCK fall: jtag_TDO <= shift_reg[0] in SH_DR/SH_IR, else holds its value.
//  - UPD_DR with IR=DMI, op!=0, not busy, sticky clear:
//      latch addr/data/op; dmi_req_valid=1 on the next clk.
//      Hold valid and all fields stable until dmi_req_ready; drop valid on the cycle after the handshake.
//  - Outstanding request (valid, or accepted but not yet answered):
//      UPD_DR(DMI) is ignored and sets sticky busy (dmistat=2'b11).
//      CAP_DR(DMI) reports 2'b11.
//  - dmi_resp_valid pulse: last_resp_data <= dmi_resp_data; outstanding cleared.
//      A response arriving in the same clk as a TCK edge is never lost.
//  - UPD_DR with IR=DTMCS and shifted bit16 (dmireset)=1 clears sticky busy; bit17 (dmihardreset) also drops a pending request.
//  - op=0 (nop) or op=3 on UPD_DR produces no request.
//  - The TAP FSM moving to TLR mid-request does not cancel an in-flight DMI handshake.
//  - Async rst mid-shift returns everything to reset values immediately.
// CONFIGURATION
//  JTAG_TAP_IDCODE_EN defined: IDCODE instruction implemented; IR resets to 0x01; CAP_DR loads IDCODE_VAL.
//  JTAG_TAP_IDCODE_EN undefined: 0x01 decodes as BYPASS; IR resets to 0x1F; TLR->SH_DR shifts a single 0 bit.
// TESTING
//  1 TMS=1 x8 rises, then RTI->SH_DR, shift 32 bits -> TDO returns 0x1E200A6F LSB first (0x00000000 then bypass bit if macro off).
//  2 IR=0x10, shift 32 DR bits of 0 -> TDO returns 0x00005061.
//  3 IR=0x11, shift {6'h10,32'h0,2'b10}, UPD_DR, ready=1 -> one valid/ready handshake, addr=0x10, data=0, op=2.
//  4 Read op {6'h11,0,2'b01}, DM responds 0x00400C82, next CAP/SH_DR -> shifted bits[33:2]=0x00400C82, status 2'b00.
//  5 Hold ready=0, issue a second UPD_DR -> no new request, capture status 2'b11; DTMCS write bit16=1 -> status 2'b00.
//  6 Assert rst mid SH_DR -> tap_state=0, jtag_TDO=0, dmi_req_valid=0 in the same cycle.

Source files
------------

// File: rtl/jtag_tap_dtm.sv
// rtl/jtag_tap_dtm.sv - JTAG TAP controller and RISC-V DTM with pins sampled in the clk domain
// Optional feature macro: JTAG_TAP_IDCODE_EN (IDCODE instruction implemented, IR resets to 0x01)
module jtag_tap_dtm #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IR_BITS     = 5,
    parameter int unsigned DMI_ABITS   = 6,
    parameter logic [31:0] IDCODE_VAL  = 32'h1E200A6F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jtag_TCK,
    input  logic                 jtag_TMS,
    input  logic                 jtag_TDI,
    output logic                 jtag_TDO,
    output logic                 dmi_req_valid,
    input  logic                 dmi_req_ready,
    output logic [DMI_ABITS-1:0] dmi_req_addr,
    output logic [31:0]          dmi_req_data,
    output logic [1:0]           dmi_req_op,
    input  logic                 dmi_resp_valid,
    input  logic [31:0]          dmi_resp_data,
    output logic [3:0]           tap_state
);

    localparam int unsigned DMI_W = DMI_ABITS + 34;
    localparam logic [IR_BITS-1:0] IR_DTMCS = IR_BITS'(5'h10);
    localparam logic [IR_BITS-1:0] IR_DMI   = IR_BITS'(5'h11);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(5'h01);
    localparam logic [IR_BITS-1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [IR_BITS-1:0] IR_RESET  = '1;
`endif

    typedef enum logic [3:0] {
        S_TLR    = 4'h0, S_RTI    = 4'h1, S_SEL_DR = 4'h2, S_CAP_DR = 4'h3,
        S_SH_DR  = 4'h4, S_EX1_DR = 4'h5, S_PA_DR  = 4'h6, S_EX2_DR = 4'h7,
        S_UPD_DR = 4'h8, S_SEL_IR = 4'h9, S_CAP_IR = 4'hA, S_SH_IR  = 4'hB,
        S_EX1_IR = 4'hC, S_PA_IR  = 4'hD, S_EX2_IR = 4'hE, S_UPD_IR = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                   tck_prev_q;
    logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;

    tap_state_e state_q, state_d;

    logic [IR_BITS-1:0] ir_q, ir_shift_q;
    logic [DMI_W-1:0]   dr_shift_q, dr_capture, dr_shifted;
    logic               tdo_q;
    dr_sel_e            dr_sel;

    logic                 req_valid_q, outstanding_q, sticky_q;
    logic [DMI_ABITS-1:0] req_addr_q, last_addr_q;
    logic [31:0]          req_data_q, last_resp_q;
    logic [1:0]           req_op_q, dmi_status, new_op;
    logic [31:0]          dtmcs_cap;
    logic                 busy, upd_dmi, upd_dtmcs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], jtag_TCK};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], jtag_TMS};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], jtag_TDI};
            tck_prev_q <= tck_s;
        end
    end

    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_TLR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                S_TLR:    state_d = tms_s ? S_TLR    : S_RTI;
                S_RTI:    state_d = tms_s ? S_SEL_DR : S_RTI;
                S_SEL_DR: state_d = tms_s ? S_SEL_IR : S_CAP_DR;
                S_CAP_DR: state_d = tms_s ? S_EX1_DR : S_SH_DR;
                S_SH_DR:  state_d = tms_s ? S_EX1_DR : S_SH_DR;
                S_EX1_DR: state_d = tms_s ? S_UPD_DR : S_PA_DR;
                S_PA_DR:  state_d = tms_s ? S_EX2_DR : S_PA_DR;
                S_EX2_DR: state_d = tms_s ? S_UPD_DR : S_SH_DR;
                S_UPD_DR: state_d = tms_s ? S_SEL_DR : S_RTI;
                S_SEL_IR: state_d = tms_s ? S_TLR    : S_CAP_IR;
                S_CAP_IR: state_d = tms_s ? S_EX1_IR : S_SH_IR;
                S_SH_IR:  state_d = tms_s ? S_EX1_IR : S_SH_IR;
                S_EX1_IR: state_d = tms_s ? S_UPD_IR : S_PA_IR;
                S_PA_IR:  state_d = tms_s ? S_EX2_IR : S_PA_IR;
                S_EX2_IR: state_d = tms_s ? S_UPD_IR : S_SH_IR;
                S_UPD_IR: state_d = tms_s ? S_SEL_DR : S_RTI;
                default:  state_d = S_TLR;
            endcase
        end
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
            IR_DTMCS:  dr_sel = DR_DTMCS;
            IR_DMI:    dr_sel = DR_DMI;
`ifdef JTAG_TAP_IDCODE_EN
            IR_IDCODE: dr_sel = DR_IDCODE;
`endif
            default:   dr_sel = DR_BYPASS;
        endcase
    end

    // dmistat reports only the sticky error; the DMI status field also reflects live busy
    assign busy       = req_valid_q | outstanding_q;
    assign dmi_status = (busy | sticky_q) ? 2'b11 : 2'b00;
    assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, 3'd5, (sticky_q ? 2'b11 : 2'b00), 6'(DMI_ABITS), 4'd1};

    always_comb begin
        dr_capture = '0;
        case (dr_sel)
            DR_IDCODE: dr_capture[31:0] = IDCODE_VAL;
            DR_DTMCS:  dr_capture[31:0] = dtmcs_cap;
            DR_DMI:    dr_capture       = {last_addr_q, last_resp_q, dmi_status};
            default:   dr_capture       = '0;
        endcase
        dr_shifted = dr_shift_q >> 1;
        case (dr_sel)
            DR_DMI:    dr_shifted[DMI_W-1] = tdi_s;
            DR_BYPASS: dr_shifted[0]       = tdi_s;
            default:   dr_shifted[31]      = tdi_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= IR_RESET;
            ir_shift_q <= '0;
            dr_shift_q <= '0;
            tdo_q      <= 1'b0;
        end else begin
            if (state_q == S_TLR) ir_q <= IR_RESET;
            if (tck_rise) begin
                case (state_q)
                    S_CAP_IR: ir_shift_q <= IR_BITS'(1);
                    S_SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_BITS-1:1]};
                    S_CAP_DR: dr_shift_q <= dr_capture;
                    S_SH_DR:  dr_shift_q <= dr_shifted;
                    default:  ;
                endcase
            end
            if (tck_fall) begin
                if (state_q == S_SH_DR)      tdo_q <= dr_shift_q[0];
                else if (state_q == S_SH_IR) tdo_q <= ir_shift_q[0];
                if (state_q == S_UPD_IR)     ir_q  <= ir_shift_q;
            end
        end
    end

    assign upd_dmi   = tck_fall && (state_q == S_UPD_DR) && (dr_sel == DR_DMI);
    assign upd_dtmcs = tck_fall && (state_q == S_UPD_DR) && (dr_sel == DR_DTMCS);
    assign new_op    = dr_shift_q[1:0];

    // Request side runs on clk only, so TAP resets never abort a handshake in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q   <= 1'b0;
            outstanding_q <= 1'b0;
            sticky_q      <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_op_q      <= '0;
            last_addr_q   <= '0;
            last_resp_q   <= '0;
        end else begin
            if (req_valid_q && dmi_req_ready) begin
                req_valid_q   <= 1'b0;
                outstanding_q <= 1'b1;
            end
            if (dmi_resp_valid) begin
                last_resp_q   <= dmi_resp_data;
                outstanding_q <= 1'b0;
            end
            if (upd_dmi) begin
                if (busy) begin
                    sticky_q <= 1'b1;
                end else if (!sticky_q && (new_op == 2'd1 || new_op == 2'd2)) begin
                    req_valid_q <= 1'b1;
                    req_addr_q  <= dr_shift_q[DMI_W-1:34];
                    req_data_q  <= dr_shift_q[33:2];
                    req_op_q    <= new_op;
                    last_addr_q <= dr_shift_q[DMI_W-1:34];
                end
            end
            if (upd_dtmcs && (dr_shift_q[16] || dr_shift_q[17])) sticky_q <= 1'b0;
            if (upd_dtmcs && dr_shift_q[17]) begin
                req_valid_q   <= 1'b0;
                outstanding_q <= 1'b0;
            end
        end
    end

    assign jtag_TDO      = tdo_q;
    assign dmi_req_valid = req_valid_q;
    assign dmi_req_addr  = req_addr_q;
    assign dmi_req_data  = req_data_q;
    assign dmi_req_op    = req_op_q;
    assign tap_state     = state_q;

endmodule

// File: tb/tb_jtag_tap_dtm.sv
// tb/tb_jtag_tap_dtm.sv - directed self-checking bench for jtag_tap_dtm
// Honours JTAG_TAP_IDCODE_EN for the expected IDCODE scan result.
module tb_jtag_tap_dtm;

    logic        clk, rst;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
    logic        dmi_req_valid, dmi_req_ready;
    logic [5:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid;
    logic [31:0] dmi_resp_data;
    logic [3:0]  tap_state;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    logic [5:0]  hs_addr;
    logic [31:0] hs_data;
    logic [1:0]  hs_op;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [63:0] IDCODE_EXP = 64'h1E200A6F;
`else
    localparam logic [63:0] IDCODE_EXP = 64'h0;
`endif

    typedef struct {
        int          id;
        logic [4:0]  ir;
        int          len;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    jtag_tap_dtm dut (
        .clk(clk), .rst(rst),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data),
        .tap_state(tap_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && dmi_req_valid && dmi_req_ready) begin
            hs_count = hs_count + 1;
            hs_addr  = dmi_req_addr;
            hs_data  = dmi_req_data;
            hs_op    = dmi_req_op;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tck(input logic tms, input logic tdi, output logic tdo);
        @(negedge clk);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        tdo = jtag_TDO;
        repeat (6) @(negedge clk);
        jtag_TCK = 1'b1;
        repeat (6) @(negedge clk);
        jtag_TCK = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck((i == n - 1), din[i], b);
            dout[i] = b;
        end
    endtask

    task automatic scan_ir(input logic [4:0] ir, output logic [4:0] out);
        logic b;
        logic [63:0] o;
        tck(1'b1, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        shift_bits(5, {59'b0, ir}, o);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        out = o[4:0];
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        shift_bits(n, din, dout);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(hs_count), 64'(target));
    endtask

    task automatic dm_respond(input logic [31:0] data);
        @(negedge clk);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = data;
        @(negedge clk);
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
    endtask

    initial begin
        logic        b;
        logic [4:0]  ir_out;
        logic [63:0] dout;

        vecs[0] = '{0, 5'h10, 32, 64'h0,        64'h5061};
        vecs[1] = '{1, 5'h10, 32, 64'h0000FFFF, 64'h5061};
        vecs[2] = '{2, 5'h01, 32, 64'h0,        IDCODE_EXP};
        vecs[3] = '{3, 5'h1F, 8,  64'hA5,       64'h4A};
        vecs[4] = '{4, 5'h05, 4,  64'hF,        64'hE};
        vecs[5] = '{5, 5'h11, 40, 64'h0,        64'h0};

        rst = 1'b1;
        jtag_TCK = 1'b0; jtag_TMS = 1'b0; jtag_TDI = 1'b0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0;
        repeat (4) @(negedge clk);
        check("reset tap_state", 64'(tap_state), 64'h0);
        check("reset tdo", 64'(jtag_TDO), 64'h0);
        check("reset req", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) tck(1'b1, 1'b0, b);
        check("tlr after tms ones", 64'(tap_state), 64'h0);
        tck(1'b0, 1'b0, b);
        check("rti state", 64'(tap_state), 64'h1);
        scan_dr(32, 64'h0, dout);
        check("idcode after reset", dout, IDCODE_EXP);

        scan_ir(5'h10, ir_out);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        check("in sh_dr", 64'(tap_state), 64'h4);
        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, b);
        check("five tms ones reach tlr", 64'(tap_state), 64'h0);
        tck(1'b0, 1'b0, b);
        scan_dr(32, 64'h0, dout);
        check("tlr restores ir", dout, IDCODE_EXP);

        for (int i = 0; i < 6; i++) begin
            scan_ir(vecs[i].ir, ir_out);
            check($sformatf("vec%0d ir capture", vecs[i].id), 64'(ir_out), 64'h01);
            scan_dr(vecs[i].len, vecs[i].din, dout);
            check($sformatf("vec%0d dr", vecs[i].id), dout, vecs[i].exp);
        end

        // DMI write handshake with ready held high
        dmi_req_ready = 1'b1;
        scan_ir(5'h11, ir_out);
        scan_dr(40, {24'b0, 6'h10, 32'h0, 2'b10}, dout);
        check("dmi first capture", dout, 64'h0);
        wait_hs(1, "write handshake");
        check("write fields", {20'b0, hs_addr, hs_data, hs_op}, {20'b0, 6'h10, 32'h0, 2'b10});
        check("valid dropped", 64'(dmi_req_valid), 64'h0);
        dm_respond(32'h0);

        // DMI read and response capture
        scan_dr(40, {24'b0, 6'h11, 32'h0, 2'b01}, dout);
        check("capture after write", dout, {24'b0, 6'h10, 32'h0, 2'b00});
        wait_hs(2, "read handshake");
        check("read fields", {20'b0, hs_addr, hs_data, hs_op}, {20'b0, 6'h11, 32'h0, 2'b01});
        dm_respond(32'h00400C82);
        scan_dr(40, 64'h0, dout);
        check("read data capture", dout, {24'b0, 6'h11, 32'h00400C82, 2'b00});
        repeat (20) @(negedge clk);
        check("nop no request", 64'(hs_count), 64'd2);

        // Busy: ready low, second update ignored and sets sticky
        dmi_req_ready = 1'b0;
        scan_dr(40, {24'b0, 6'h12, 32'hDEADBEEF, 2'b10}, dout);
        check("capture before busy", dout, {24'b0, 6'h11, 32'h00400C82, 2'b00});
        repeat (20) @(negedge clk);
        check("held request", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op},
              {1'b1, 6'h12, 32'hDEADBEEF, 2'b10});
        scan_dr(40, {24'b0, 6'h13, 32'h0, 2'b01}, dout);
        check("busy status", dout, {24'b0, 6'h12, 32'h00400C82, 2'b11});
        check("request unchanged", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op},
              {1'b1, 6'h12, 32'hDEADBEEF, 2'b10});
        dmi_req_ready = 1'b1;
        wait_hs(3, "late handshake");
        dm_respond(32'h12345678);
        scan_dr(40, 64'h0, dout);
        check("sticky status", dout, {24'b0, 6'h12, 32'h12345678, 2'b11});
        scan_ir(5'h10, ir_out);
        scan_dr(32, 64'h00010000, dout);
        check("dtmcs dmistat sticky", dout, 64'h5C61);
        scan_dr(32, 64'h0, dout);
        check("dtmcs after dmireset", dout, 64'h5061);
        scan_ir(5'h11, ir_out);
        scan_dr(40, 64'h0, dout);
        check("status cleared", dout, {24'b0, 6'h12, 32'h12345678, 2'b00});
        check("no extra request", 64'(hs_count), 64'd3);

        // dmihardreset drops a pending request
        dmi_req_ready = 1'b0;
        scan_dr(40, {24'b0, 6'h20, 32'h0, 2'b10}, dout);
        repeat (10) @(negedge clk);
        check("pending before hardreset", 64'(dmi_req_valid), 64'h1);
        scan_ir(5'h10, ir_out);
        scan_dr(32, 64'h00020000, dout);
        check("dtmcs before hardreset", dout, 64'h5061);
        check("hardreset drops valid", 64'(dmi_req_valid), 64'h0);

        // Async reset in the middle of a DR shift
        scan_ir(5'h11, ir_out);
        scan_dr(40, {24'b0, 6'h21, 32'h1, 2'b10}, dout);
        check("capture after hardreset", dout, {24'b0, 6'h20, 32'h12345678, 2'b00});
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        check("pre-reset state", {59'b0, dmi_req_valid, tap_state}, {59'b0, 1'b1, 4'h4});
        check("pre-reset tdo", 64'(jtag_TDO), 64'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset tap_state", 64'(tap_state), 64'h0);
        check("async reset tdo", 64'(jtag_TDO), 64'h0);
        check("async reset valid", 64'(dmi_req_valid), 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
